// File: rtl/ternary_fabric_pkg.sv
// Shared ternary-fabric definitions: fetch FSM encoding and default SRAM geometry.
package ternary_fabric_pkg;

    localparam int TSF_ADDR_WIDTH = 12;
    localparam int TRIT_BITS      = 2;
    localparam int TSF_DATA_WIDTH = 12 * TRIT_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } tsf_state_e;

endpackage

// File: rtl/tsf_skid_fifo.sv
// Two-entry synchronous FIFO holding returned {weight, input, last} beats for the fetch engine.
module tsf_skid_fifo
    import ternary_fabric_pkg::*;
#(
    parameter int WIDTH = 2 * TSF_DATA_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign valid = (count_q != 2'd0);
    assign count = count_q;

endmodule

// File: rtl/ternary_sram_fetch_engine.sv
// Dual-bank ternary SRAM read initiator streaming {weight,input} pairs with backpressure.
// Optional stall counter enabled by defining TSF_FETCH_PERF_EN.
module ternary_sram_fetch_engine
    import ternary_fabric_pkg::*;
#(
    parameter int ADDR_WIDTH = TSF_ADDR_WIDTH,
    parameter int DATA_WIDTH = TSF_DATA_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_en_a,
    output logic [ADDR_WIDTH-1:0] sram_addr_a,
    output logic                  sram_we_a,
    output logic [DATA_WIDTH-1:0] sram_din_a,
    input  logic [DATA_WIDTH-1:0] sram_dout_a,
    output logic                  sram_en_b,
    output logic [ADDR_WIDTH-1:0] sram_addr_b,
    output logic                  sram_we_b,
    output logic [DATA_WIDTH-1:0] sram_din_b,
    input  logic [DATA_WIDTH-1:0] sram_dout_b,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_weight,
    output logic [DATA_WIDTH-1:0] m_input,
    output logic                  m_last,
    output logic [31:0]           stall_cycles
);

    localparam int FIFO_W = 2 * DATA_WIDTH + 1;

    tsf_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  fifo_valid;
    logic [1:0]            fifo_count;
    logic [FIFO_W-1:0]     fifo_dout;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occupancy;

    tsf_skid_fifo #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .din   ({sram_dout_a, sram_dout_b, inflight_last_q}),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    always_comb begin
        pop       = fifo_valid & m_ready;
        // Slots committed after this cycle's pop; a new read may only be issued into a free slot.
        occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (state_q == ST_FETCH) && (issued_q != len_q) && (occupancy < 3'd2);

        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        len_d    = len_q;
        issued_d = issued_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_FETCH;
                        addr_a_d = base_a;
                        addr_b_d = base_b;
                        len_d    = len;
                        issued_d = '0;
                    end
                end
            end
            ST_FETCH: begin
                if (issue) begin
                    addr_a_d = addr_a_q + ADDR_WIDTH'(1);
                    addr_b_d = addr_b_q + ADDR_WIDTH'(1);
                    issued_d = issued_q + LEN_WIDTH'(1);
                end
                if (issued_q == len_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_dout[0]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        inflight_d      = issue;
        inflight_last_d = issue && (issued_q == len_q - LEN_WIDTH'(1));
        busy_d          = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
        done_d          = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_a_q        <= '0;
            addr_b_q        <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_a_q        <= addr_a_d;
            addr_b_q        <= addr_b_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sram_en_a   = issue;
    assign sram_en_b   = issue;
    assign sram_addr_a = addr_a_q;
    assign sram_addr_b = addr_b_q;
    assign sram_we_a   = 1'b0;
    assign sram_we_b   = 1'b0;
    assign sram_din_a  = '0;
    assign sram_din_b  = '0;

    // Data is gated by valid so an empty FIFO presents zeros rather than stale words.
    assign m_valid  = fifo_valid;
    assign m_weight = fifo_valid ? fifo_dout[DATA_WIDTH+1 +: DATA_WIDTH] : '0;
    assign m_input  = fifo_valid ? fifo_dout[1 +: DATA_WIDTH] : '0;
    assign m_last   = fifo_valid & fifo_dout[0];

`ifdef TSF_FETCH_PERF_EN
    logic [31:0] stall_q, stall_d;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) && start) begin
            stall_d = '0;
        end else if (fifo_valid && !m_ready) begin
            stall_d = sat_inc32(stall_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ternary_sram_fetch_engine.sv
// Scoreboard bench for ternary_sram_fetch_engine with a behavioural 1-cycle-latency SRAM pair.
module tb_ternary_sram_fetch_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] base_a, base_b;
    logic [12:0] len;
    logic        busy, done;
    logic        sram_en_a, sram_we_a, sram_en_b, sram_we_b;
    logic [11:0] sram_addr_a, sram_addr_b;
    logic [23:0] sram_din_a, sram_din_b, sram_dout_a, sram_dout_b;
    logic        m_valid, m_ready, m_last;
    logic [23:0] m_weight, m_input;
    logic [31:0] stall_cycles;

    ternary_sram_fetch_engine dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_a       (base_a),
        .base_b       (base_b),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .sram_en_a    (sram_en_a),
        .sram_addr_a  (sram_addr_a),
        .sram_we_a    (sram_we_a),
        .sram_din_a   (sram_din_a),
        .sram_dout_a  (sram_dout_a),
        .sram_en_b    (sram_en_b),
        .sram_addr_b  (sram_addr_b),
        .sram_we_b    (sram_we_b),
        .sram_din_b   (sram_din_b),
        .sram_dout_b  (sram_dout_b),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_weight     (m_weight),
        .m_input      (m_input),
        .m_last       (m_last),
        .stall_cycles (stall_cycles)
    );

    logic [23:0] mem_a [4096];
    logic [23:0] mem_b [4096];

    logic [48:0] exp_beats [$];
    logic [23:0] exp_addr [$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int en_cnt, beats, done_cnt, done_cyc, first_cyc, last_cyc, last_cnt;
    int stall_cnt, iss_cnt, pop_cnt, max_out;
    bit busy_seen;
    bit stall_pend = 0;
    logic [23:0] hold_w, hold_i;
    logic        hold_l;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (sram_en_a) sram_dout_a <= mem_a[sram_addr_a];
        if (sram_en_b) sram_dout_b <= mem_b[sram_addr_b];
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: scoreboard compare, address tracking, stall stability.
    always @(negedge clk) begin
        logic [48:0] b;
        logic [23:0] a;
        if (!rst) begin
            if ((iss_cnt - pop_cnt) > max_out) max_out = iss_cnt - pop_cnt;
            if (busy) busy_seen = 1'b1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (sram_en_a || sram_en_b) begin
                check_eq("en_pair", sram_en_b, sram_en_a);
                check_eq("addr_expected", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) begin
                    a = exp_addr.pop_front();
                    check_eq("addr_a", sram_addr_a, a[23:12]);
                    check_eq("addr_b", sram_addr_b, a[11:0]);
                end
                iss_cnt++;
                en_cnt++;
            end
            if (stall_pend) begin
                check_eq("valid_hold", m_valid, 1);
                check_eq("hold_weight", m_weight, hold_w);
                check_eq("hold_input", m_input, hold_i);
                check_eq("hold_last", m_last, hold_l);
            end
            stall_pend = 1'b0;
            if (m_valid) begin
                if (m_ready) begin
                    check_eq("beat_expected", exp_beats.size() != 0, 1);
                    if (exp_beats.size() != 0) begin
                        b = exp_beats.pop_front();
                        check_eq("weight", m_weight, b[48:25]);
                        check_eq("input", m_input, b[24:1]);
                        check_eq("last", m_last, b[0]);
                    end
                    if (beats == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    beats++;
                    pop_cnt++;
                    if (m_last) last_cnt++;
                end else begin
                    stall_pend = 1'b1;
                    hold_w = m_weight;
                    hold_i = m_input;
                    hold_l = m_last;
                    stall_cnt++;
                end
            end
        end else begin
            stall_pend = 1'b0;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_en_a"}, sram_en_a, 0);
        check_eq({tag, "_en_b"}, sram_en_b, 0);
        check_eq({tag, "_valid"}, m_valid, 0);
        check_eq({tag, "_last"}, m_last, 0);
        check_eq({tag, "_weight"}, m_weight, 0);
        check_eq({tag, "_input"}, m_input, 0);
        check_eq({tag, "_addr_a"}, sram_addr_a, 0);
        check_eq({tag, "_addr_b"}, sram_addr_b, 0);
        check_eq({tag, "_stall"}, stall_cycles, 0);
    endtask

    // mode 0: m_ready held high; mode 1: ready pattern 1,0,0 repeating.
    task automatic run_cmd(input logic [11:0] ba, input logic [11:0] bb, input logic [12:0] ln,
                           input int mode, input int abort_at, input bit mid_start);
        logic [11:0] aa, ab;
        int s, n, bound, en_before;
        for (int i = 0; i < int'(ln); i++) begin
            aa = ba + 12'(i);
            ab = bb + 12'(i);
            exp_beats.push_back({mem_a[aa], mem_b[ab], (i == int'(ln) - 1)});
            exp_addr.push_back({aa, ab});
        end
        en_cnt = 0; beats = 0; done_cnt = 0; done_cyc = -1; first_cyc = -1; last_cyc = -1;
        last_cnt = 0; stall_cnt = 0; iss_cnt = 0; pop_cnt = 0; max_out = 0; busy_seen = 1'b0;

        @(posedge clk); #1;
        base_a = ba; base_b = bb; len = ln; start = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s = cyc;
        bound = int'(ln) * 4 + 50;
        n = 0;
        while (done_cnt == 0 && n < bound) begin
            m_ready = (mode == 0) ? 1'b1 : ((n % 3) == 0);
            if (mid_start && n == 3) begin
                start = 1'b1; base_a = 12'h123; base_b = 12'h456; len = 13'd5;
            end else begin
                start = 1'b0;
            end
            if (abort_at != 0 && pop_cnt >= abort_at) break;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        m_ready = 1'b1;

        if (abort_at != 0) begin
            rst = 1'b1;
            @(posedge clk); #1;
            check_idle_outputs("abort");
            rst = 1'b0;
            exp_beats.delete();
            exp_addr.delete();
            en_before = en_cnt;
            repeat (8) @(posedge clk);
            #1;
            check_eq("abort_no_done", done_cnt, 0);
            check_eq("abort_no_en", en_cnt, en_before);
        end else begin
            repeat (2) @(posedge clk);
            #1;
            check_eq("done_count", done_cnt, 1);
            check_eq("busy_after", busy, 0);
            check_eq("en_count", en_cnt, ln);
            check_eq("beat_count", beats, ln);
            check_eq("last_count", last_cnt, (ln != 0));
            check_eq("beats_left", exp_beats.size(), 0);
            check_eq("busy_seen", busy_seen, (ln != 0));
            check_eq("outstanding_le2", max_out <= 2, 1);
            if (ln == 0) begin
                check_eq("done_cyc_len0", done_cyc, s);
            end else begin
                check_eq("done_cyc", done_cyc, last_cyc + 1);
                if (mode == 0) begin
                    check_eq("first_beat_cyc", first_cyc, s + 2);
                    check_eq("last_beat_cyc", last_cyc, s + 1 + int'(ln));
                end
            end
`ifdef TSF_FETCH_PERF_EN
            check_eq("stall_cycles", stall_cycles, stall_cnt);
`else
            check_eq("stall_cycles_off", stall_cycles, 0);
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = 24'h555550 + 24'(i);
            mem_b[i] = 24'hAAAAA0 + 24'(i);
        end
        rst = 1'b1; start = 1'b0; base_a = '0; base_b = '0; len = '0; m_ready = 1'b1;
        sram_dout_a = '0; sram_dout_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check_eq("we_a", sram_we_a, 0);
        check_eq("we_b", sram_we_b, 0);
        check_eq("din_a", sram_din_a, 0);
        check_eq("din_b", sram_din_b, 0);
        rst = 1'b0;

        run_cmd(12'h000, 12'h000, 13'd8, 0, 0, 1'b0);
        run_cmd(12'h000, 12'h000, 13'd8, 1, 0, 1'b0);
        run_cmd(12'hFFE, 12'h010, 13'd4, 0, 0, 1'b0);
        run_cmd(12'h000, 12'h000, 13'd0, 0, 0, 1'b0);
        run_cmd(12'h000, 12'h000, 13'd8, 0, 0, 1'b1);
        run_cmd(12'h000, 12'h000, 13'd8, 0, 3, 1'b0);
        run_cmd(12'h005, 12'h007, 13'd6, 1, 0, 1'b0);
        run_cmd(12'h000, 12'h000, 13'd4096, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
